multicycle_control_unit: RTL and testbench

Moore-style FSM controller for the multi-cycle RV32I datapath. It replaces the single-cycle opcode decoder: it sequences each instruction through fetch, decode, execute, memory and writeback over several clock cycles and drives every datapath mux, enable and memory strobe. It supports a wait-state handshake with the unified instruction/data memory and parameter-enabled JAL/LUI support. Unsupported opcodes trap.

---
 rtl/multicycle_control_unit_pkg.sv | 83 ++++++++
 rtl/opcode_class_decode.sv | 38 +++
 rtl/multicycle_control_unit.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcode
// constants, FSM state encodings, datapath mux select codes, the opcode
// class vector produced by opcode_class_decode and the control word the
// FSM drives onto the datapath.
package multicycle_control_unit_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // State codes are visible on the State debug port, so they are fixed.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_LUI    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Writeback / PC-update result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // One-hot-ish opcode classification; exactly one bit is set.
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_r;
    logic is_i;
    logic is_beq;
    logic is_jal;
    logic is_lui;
    logic is_illegal;
  } op_class_t;

  // Full datapath control word driven by the FSM.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_rw;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier for the multi-cycle control unit.
// Ports:
//   opcode   in  7  instr[6:0] from the instruction register
//   op_class out    class vector; JAL/LUI fall into is_illegal when their
//                   ENABLE_* parameter is 0
module opcode_class_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1,
  parameter bit ENABLE_LUI = 1'b1
) (
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    op_class = '0;
    unique case (opcode)
      OP_LOAD:   op_class.is_load  = 1'b1;
      OP_STORE:  op_class.is_store = 1'b1;
      OP_R:      op_class.is_r     = 1'b1;
      OP_OPIMM:  op_class.is_i     = 1'b1;
      OP_BRANCH: op_class.is_beq   = 1'b1;
      OP_JAL: begin
        if (ENABLE_JAL) op_class.is_jal     = 1'b1;
        else            op_class.is_illegal = 1'b1;
      end
      OP_LUI: begin
        if (ENABLE_LUI) op_class.is_lui     = 1'b1;
        else            op_class.is_illegal = 1'b1;
      end
      default:   op_class.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multi-cycle RV32I datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, driving every
// datapath mux, enable and memory strobe, with a mem_ready wait-state
// handshake on the unified memory. Unsupported opcodes enter an absorbing
// TRAP state that only rst leaves.
// Ports:
//   clk, rst (synchronous, active-high; forces every output to 0)
//   opcode, zero, mem_ready                  status inputs
//   PCWrite, IRWrite, AdrSrc, MemReq, MemRW,
//   RegWrite, Branch                         enables / strobes
//   ALUSrcA, ALUSrcB, ALUOp, ResultSrc       mux selects
//   InstrDone (last cycle of an instruction), Illegal (in TRAP), State
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1,
  parameter bit ENABLE_LUI = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemReq,
  output logic       MemRW,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t    state_q, state_d;
  op_class_t cls;
  ctrl_t     ctrl, ctrl_out;

  opcode_class_decode #(
    .ENABLE_JAL (ENABLE_JAL),
    .ENABLE_LUI (ENABLE_LUI)
  ) u_decode (
    .opcode   (opcode),
    .op_class (cls)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        if (cls.is_illegal)                 state_d = S_TRAP;
        else if (cls.is_load | cls.is_store) state_d = S_MEMADR;
        else if (cls.is_r)                  state_d = S_EXECR;
        else if (cls.is_i)                  state_d = S_EXECI;
        else if (cls.is_beq)                state_d = S_BEQ;
        else if (cls.is_jal)                state_d = S_JAL;
        else if (cls.is_lui)                state_d = S_LUI;
        else                                state_d = S_TRAP;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        // The IR still holds the instruction, so the class is still valid.
        state_d = cls.is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_rw     = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JAL: begin
        // PC loads the target from ALUOut while the ALU forms OldPC+4
        // for the link register write in ALUWB.
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        state_d         = S_ALUWB;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ALUWB;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
        state_d      = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks the outputs combinationally so an in-flight memory request
  // or write strobe drops in the very cycle rst is raised.
  assign ctrl_out  = rst ? '0 : ctrl;
  assign State     = rst ? 4'd0 : state_q;

  assign PCWrite   = ctrl_out.pc_write;
  assign IRWrite   = ctrl_out.ir_write;
  assign AdrSrc    = ctrl_out.adr_src;
  assign MemReq    = ctrl_out.mem_req;
  assign MemRW     = ctrl_out.mem_rw;
  assign RegWrite  = ctrl_out.reg_write;
  assign Branch    = ctrl_out.branch;
  assign ALUSrcA   = ctrl_out.alu_src_a;
  assign ALUSrcB   = ctrl_out.alu_src_b;
  assign ALUOp     = ctrl_out.alu_op;
  assign ResultSrc = ctrl_out.result_src;
  assign InstrDone = ctrl_out.instr_done;
  assign Illegal   = ctrl_out.illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. An instruction-level
// model expands each instruction (kind, wait states, zero flag) into the
// per-cycle output vectors the datapath should see; directed instructions
// come first, then a randomized instruction stream, then trap/reset cases.
// A second instance with ENABLE_JAL=0 covers the disabled-JAL trap.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       rst, zero, mem_ready;
  logic [6:0] opcode;
  logic       a_pcw, a_irw, a_adr, a_req, a_rw, a_regw, a_br, a_done, a_ill;
  logic [1:0] a_sa, a_sb, a_op, a_rs;
  logic [3:0] a_state;

  // Instance B: JAL disabled
  logic       rst2, zero2, mem_ready2;
  logic [6:0] opcode2;
  logic       b_pcw, b_irw, b_adr, b_req, b_rw, b_regw, b_br, b_done, b_ill;
  logic [1:0] b_sa, b_sb, b_op, b_rs;
  logic [3:0] b_state;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .IRWrite(a_irw), .AdrSrc(a_adr), .MemReq(a_req),
    .MemRW(a_rw), .RegWrite(a_regw), .Branch(a_br), .ALUSrcA(a_sa),
    .ALUSrcB(a_sb), .ALUOp(a_op), .ResultSrc(a_rs), .InstrDone(a_done),
    .Illegal(a_ill), .State(a_state)
  );

  multicycle_control_unit #(.ENABLE_JAL(1'b0), .ENABLE_LUI(1'b1)) dut_nojal (
    .clk(clk), .rst(rst2), .opcode(opcode2), .zero(zero2), .mem_ready(mem_ready2),
    .PCWrite(b_pcw), .IRWrite(b_irw), .AdrSrc(b_adr), .MemReq(b_req),
    .MemRW(b_rw), .RegWrite(b_regw), .Branch(b_br), .ALUSrcA(b_sa),
    .ALUSrcB(b_sb), .ALUOp(b_op), .ResultSrc(b_rs), .InstrDone(b_done),
    .Illegal(b_ill), .State(b_state)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pcw, irw, adr, req, rw, regw, br;
    logic [1:0] sa, sb, op, rs;
    logic       done, ill;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {a_state, a_pcw, a_irw, a_adr, a_req, a_rw, a_regw, a_br,
                  a_sa, a_sb, a_op, a_rs, a_done, a_ill};
  assign obs_b = {b_state, b_pcw, b_irw, b_adr, b_req, b_rw, b_regw, b_br,
                  b_sa, b_sb, b_op, b_rs, b_done, b_ill};

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL, K_LUI} kind_t;

  typedef struct {
    obs_t       exp;
    bit         sel;   // 0 = instance A, 1 = instance B
    bit         rst;
    bit         mr;
    bit         z;
    logic [6:0] op;
  } cyc_t;

  cyc_t  plan[$];
  string tags[$];
  bit    cur_sel = 1'b0;
  int    total = 0, passed = 0, failed = 0;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic [6:0] opcode_of(kind_t k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_BEQ:   return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b0110111;
    endcase
  endfunction

  task automatic push(obs_t e, bit r, bit mr, bit z, logic [6:0] op, string tag);
    cyc_t c;
    c.exp = e; c.sel = cur_sel; c.rst = r; c.mr = mr; c.z = z; c.op = op;
    plan.push_back(c);
    tags.push_back(tag);
  endtask

  // Expected output vectors for each phase of an instruction.
  function automatic obs_t o_fetch(bit done);
    obs_t o = '0;
    o.state = 4'd0; o.req = 1'b1; o.sb = 2'b10; o.rs = 2'b10;
    o.irw = done; o.pcw = done;
    return o;
  endfunction

  function automatic obs_t o_decode();
    obs_t o = '0;
    o.state = 4'd1; o.sa = 2'b01; o.sb = 2'b01;
    return o;
  endfunction

  function automatic obs_t o_memadr();
    obs_t o = '0;
    o.state = 4'd2; o.sa = 2'b10; o.sb = 2'b01;
    return o;
  endfunction

  function automatic obs_t o_memwr(bit done);
    obs_t o = '0;
    o.state = 4'd5; o.req = 1'b1; o.rw = 1'b1; o.adr = 1'b1; o.done = done;
    return o;
  endfunction

  function automatic obs_t o_aluwb();
    obs_t o = '0;
    o.state = 4'd8; o.regw = 1'b1; o.done = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_trap();
    obs_t o = '0;
    o.state = 4'd12; o.ill = 1'b1;
    return o;
  endfunction

  // Fetch with fw wait states, then decode of opcode op.
  task automatic plan_front(int fw, logic [6:0] op, string t);
    for (int i = 0; i < fw; i++) push(o_fetch(1'b0), 1'b0, 1'b0, rb(), rop(), {t, "_fetchwait"});
    push(o_fetch(1'b1), 1'b0, 1'b1, rb(), rop(), {t, "_fetch"});
    push(o_decode(), 1'b0, rb(), rb(), op, {t, "_decode"});
  endtask

  // Complete instruction: fw fetch waits, mw memory waits, zv = ALU zero in BEQ.
  task automatic plan_instr(kind_t k, int fw, int mw, bit zv, string t);
    obs_t       o;
    logic [6:0] op = opcode_of(k);
    plan_front(fw, op, t);
    case (k)
      K_R, K_I: begin
        o = '0;
        o.state = (k == K_R) ? 4'd6 : 4'd7;
        o.sa = 2'b10; o.sb = (k == K_R) ? 2'b00 : 2'b01; o.op = 2'b10;
        push(o, 1'b0, rb(), rb(), op, {t, "_exec"});
        push(o_aluwb(), 1'b0, rb(), rb(), op, {t, "_aluwb"});
      end
      K_LW: begin
        push(o_memadr(), 1'b0, rb(), rb(), op, {t, "_memadr"});
        o = '0; o.state = 4'd3; o.req = 1'b1; o.adr = 1'b1;
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'b0, rb(), op, {t, "_memrdwait"});
        push(o, 1'b0, 1'b1, rb(), op, {t, "_memrd"});
        o = '0; o.state = 4'd4; o.rs = 2'b01; o.regw = 1'b1; o.done = 1'b1;
        push(o, 1'b0, rb(), rb(), op, {t, "_memwb"});
      end
      K_SW: begin
        push(o_memadr(), 1'b0, rb(), rb(), op, {t, "_memadr"});
        for (int i = 0; i < mw; i++) push(o_memwr(1'b0), 1'b0, 1'b0, rb(), op, {t, "_memwrwait"});
        push(o_memwr(1'b1), 1'b0, 1'b1, rb(), op, {t, "_memwr"});
      end
      K_BEQ: begin
        o = '0; o.state = 4'd9; o.sa = 2'b10; o.op = 2'b01;
        o.br = 1'b1; o.pcw = zv; o.done = 1'b1;
        push(o, 1'b0, rb(), zv, op, {t, "_beq"});
      end
      K_JAL: begin
        o = '0; o.state = 4'd10; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1;
        push(o, 1'b0, rb(), rb(), op, {t, "_jal"});
        push(o_aluwb(), 1'b0, rb(), rb(), op, {t, "_aluwb"});
      end
      default: begin
        o = '0; o.state = 4'd11; o.sa = 2'b11; o.sb = 2'b01;
        push(o, 1'b0, rb(), rb(), op, {t, "_lui"});
        push(o_aluwb(), 1'b0, rb(), rb(), op, {t, "_aluwb"});
      end
    endcase
  endtask

  task automatic check(string tag, obs_t got, obs_t exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b (state %0d vs %0d)",
             tag, got, exp, got.state, exp.state);
    end
  endtask

  initial begin
    cyc_t  c;
    string t;

    rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0;
    rst2 = 1'b1; zero2 = 1'b0; mem_ready2 = 1'b0; opcode2 = '0;

    // Reset: outputs zero regardless of mem_ready/zero.
    push('0, 1'b1, 1'b1, 1'b1, rop(), "reset0");
    push('0, 1'b1, rb(), rb(), rop(), "reset1");

    // Directed instructions.
    plan_instr(K_R,   0, 0, 1'b0, "r_add");
    plan_instr(K_LW,  0, 2, 1'b0, "lw_2wait");
    plan_instr(K_BEQ, 0, 0, 1'b1, "beq_taken");
    plan_instr(K_BEQ, 0, 0, 1'b0, "beq_not");
    plan_instr(K_JAL, 0, 0, 1'b0, "jal");
    plan_instr(K_SW,  1, 1, 1'b0, "sw_waits");
    plan_instr(K_LUI, 0, 0, 1'b0, "lui");
    plan_instr(K_I,   2, 0, 1'b0, "opimm");

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      kind_t k = kind_t'($urandom_range(0, 6));
      plan_instr(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb(),
                 $sformatf("rnd%0d", n));
    end

    // Illegal opcode traps; a one-cycle reset pulse recovers to FETCH.
    plan_front(0, 7'b1111111, "illegal");
    for (int i = 0; i < 5; i++) push(o_trap(), 1'b0, rb(), rb(), rop(), "illegal_trap");
    push('0, 1'b1, rb(), rb(), rop(), "illegal_rst");
    plan_instr(K_R, 1, 0, 1'b0, "after_trap");

    // Store aborted by reset while waiting in MEMWR.
    plan_front(0, opcode_of(K_SW), "sw_abort");
    push(o_memadr(), 1'b0, rb(), rb(), opcode_of(K_SW), "sw_abort_memadr");
    push(o_memwr(1'b0), 1'b0, 1'b0, rb(), opcode_of(K_SW), "sw_abort_wait");
    push('0, 1'b1, 1'b0, rb(), opcode_of(K_SW), "sw_abort_rst");
    plan_instr(K_LW, 0, 0, 1'b0, "after_abort");

    // ENABLE_JAL=0 instance: JAL traps and stays there with no InstrDone.
    cur_sel = 1'b1;
    push('0, 1'b1, rb(), rb(), rop(), "nojal_rst");
    push(o_fetch(1'b1), 1'b0, 1'b1, rb(), rop(), "nojal_fetch");
    push(o_decode(), 1'b0, rb(), rb(), 7'b1101111, "nojal_decode");
    for (int i = 0; i < 20; i++) push(o_trap(), 1'b0, rb(), rb(), rop(), "nojal_trap");

    while (plan.size() > 0) begin
      c = plan.pop_front();
      t = tags.pop_front();
      @(negedge clk);
      if (!c.sel) begin
        rst = c.rst; mem_ready = c.mr; zero = c.z; opcode = c.op;
        rst2 = 1'b1;
      end else begin
        rst2 = c.rst; mem_ready2 = c.mr; zero2 = c.z; opcode2 = c.op;
        rst = 1'b1;
      end
      #1;
      check(t, c.sel ? obs_b : obs_a, c.exp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
